ras_ckpt: RTL and testbench

- Parametrised, checkpointed return address stack (RAS) for the out-of-order RV32IM front end.
- Fetch pushes call return addresses and pops predicted returns speculatively.
- Each branch snapshots RAS state into one of NUM_CKPT checkpoint slots.
- On mispredict, the back end restores the snapshot in one cycle. Commit/flush logic frees slots by mask.

---
 rtl/ras_ckpt.sv | 127 ++++++++++++
 tb/tb_ras_ckpt.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Checkpointed return address stack: circular stack with speculative push/pop
// and single-cycle restore of {top, count, top entry} from checkpoint slots.
module ras_ckpt #(
    parameter int XLEN        = 32,
    parameter int STACK_DEPTH = 16,
    parameter int NUM_CKPT    = 4,
    localparam int PW         = $clog2(STACK_DEPTH),
    localparam int CW         = PW + 1,
    localparam int IW         = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                pop_push,
    input  logic [XLEN-1:0]     din,
    output logic [XLEN-1:0]     dout,
    output logic                empty,
    output logic                full,
    input  logic                ckpt_valid,
    output logic                ckpt_ready,
    output logic [IW-1:0]       ckpt_id,
    input  logic                restore_valid,
    input  logic [IW-1:0]       restore_id,
    input  logic [NUM_CKPT-1:0] free_mask
);

    logic [XLEN-1:0]     stack [STACK_DEPTH];
    logic [PW-1:0]       top;
    logic [CW-1:0]       count;

    logic [NUM_CKPT-1:0] slot_vld;
    logic [PW-1:0]       slot_top [NUM_CKPT];
    logic [CW-1:0]       slot_cnt [NUM_CKPT];
    logic [XLEN-1:0]     slot_val [NUM_CKPT];

    logic [PW-1:0]       top_m1;
    logic                restore_hit;
    logic                alloc;
    logic [PW-1:0]       top_n;
    logic [CW-1:0]       count_n;
    logic                wr_en;
    logic [PW-1:0]       wr_idx;
    logic [XLEN-1:0]     wr_data;

    assign top_m1 = top - 1'b1;
    assign empty  = (count == '0);
    assign full   = (count == CW'(STACK_DEPTH));
    assign dout   = empty ? '0 : stack[top_m1];

    assign ckpt_ready = |(~slot_vld);

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        ckpt_id = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--)
            if (!slot_vld[i]) ckpt_id = IW'(i);
    end

    assign restore_hit = restore_valid && (32'(restore_id) < NUM_CKPT) && slot_vld[restore_id];
    assign alloc       = ckpt_valid && ckpt_ready && !restore_hit;

    always_comb begin
        top_n   = top;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = top;
        wr_data = din;
        if (restore_hit) begin
            // Rewrite the saved top entry: a later push may have clobbered it.
            top_n   = slot_top[restore_id];
            count_n = slot_cnt[restore_id];
            wr_en   = 1'b1;
            wr_idx  = slot_top[restore_id] - 1'b1;
            wr_data = slot_val[restore_id];
        end else if (pop_push && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_m1;
        end else if (pop_push || push) begin
            wr_en   = 1'b1;
            top_n   = top + 1'b1;
            count_n = full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            top_n   = top_m1;
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
        end else begin
            top   <= top_n;
            count <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) stack[wr_idx] <= wr_data;
    end

    // Allocation is applied last so it beats a same-cycle free of that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (free_mask[i] || (restore_hit && restore_id == IW'(i)))
                    slot_vld[i] <= 1'b0;
                if (alloc && ckpt_id == IW'(i))
                    slot_vld[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (alloc && ckpt_id == IW'(i)) begin
                slot_top[i] <= top;
                slot_cnt[i] <= count;
                slot_val[i] <= stack[top_m1];
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: stack ops, wrap/saturation, checkpoint
// allocation, restore priority and asynchronous reset.
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push, pop, pop_push;
    logic [31:0] din;
    logic [31:0] dout;
    logic        empty, full;
    logic        ckpt_valid, ckpt_ready;
    logic [1:0]  ckpt_id;
    logic        restore_valid;
    logic [1:0]  restore_id;
    logic [3:0]  free_mask;

    int checks = 0;
    int errors = 0;

    ras_ckpt #(.XLEN(32), .STACK_DEPTH(16), .NUM_CKPT(4)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pop_push(pop_push),
        .din(din), .dout(dout), .empty(empty), .full(full),
        .ckpt_valid(ckpt_valid), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
        .restore_valid(restore_valid), .restore_id(restore_id), .free_mask(free_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        push = 0; pop = 0; pop_push = 0; din = '0;
        ckpt_valid = 0; restore_valid = 0; restore_id = '0; free_mask = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic do_push(input logic [31:0] d);
        push = 1; din = d; tick();
    endtask

    task automatic do_pop();
        pop = 1; tick();
    endtask

    initial begin
        clr();
        rst_n = 0;
        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", dout, 0);
        chk("rst_ready", 32'(ckpt_ready), 1);
        chk("rst_id", 32'(ckpt_id), 0);
        rst_n = 1;

        // basic push/pop
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        chk("push3_dout", dout, 32'h300);
        do_pop(); do_pop();
        chk("pop2_dout", dout, 32'h100);
        do_pop();
        chk("pop3_empty", 32'(empty), 1);
        do_pop();
        chk("underflow_empty", 32'(empty), 1);
        chk("underflow_dout", dout, 0);
        do_push(32'h55);
        chk("after_underflow_dout", dout, 32'h55);
        do_pop();
        chk("after_underflow_empty", 32'(empty), 1);

        // fill, overflow, drain
        for (int i = 1; i <= 16; i++) do_push(32'(i));
        chk("fill16_full", 32'(full), 1);
        chk("fill16_dout", dout, 32'h10);
        do_push(32'h11);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_dout", dout, 32'h11);
        for (int i = 1; i <= 15; i++) begin
            do_pop();
            chk("drain_dout", dout, 32'(17 - i));
        end
        chk("drain15_empty", 32'(empty), 0);
        do_pop();
        chk("drain16_empty", 32'(empty), 1);
        chk("drain16_dout", dout, 0);

        // checkpoint + speculative ops + restore
        do_push(32'h40); do_push(32'h80);
        chk("ck_id0", 32'(ckpt_id), 0);
        ckpt_valid = 1; pop = 1; tick();
        chk("ck_pop_dout", dout, 32'h40);
        chk("ck_id1", 32'(ckpt_id), 1);
        do_pop();
        chk("spec_empty", 32'(empty), 1);
        do_push(32'hAA);
        chk("spec_push", dout, 32'hAA);
        pop_push = 1; din = 32'hBB; tick();
        chk("spec_pp", dout, 32'hBB);
        restore_valid = 1; restore_id = 0; tick();
        chk("rest_dout", dout, 32'h80);
        chk("rest_ready", 32'(ckpt_ready), 1);
        chk("rest_id", 32'(ckpt_id), 0);
        // only the top entry is repaired; the one below still holds the clobber
        do_pop();
        chk("rest_pop_dout", dout, 32'hBB);
        do_pop();
        chk("rest_pop2_empty", 32'(empty), 1);

        // slot allocation
        for (int i = 0; i < 4; i++) begin
            chk("alloc_id", 32'(ckpt_id), 32'(i));
            ckpt_valid = 1; tick();
        end
        chk("alloc4_ready", 32'(ckpt_ready), 0);
        ckpt_valid = 1; tick();
        chk("alloc5_ready", 32'(ckpt_ready), 0);
        free_mask = 4'b0100;
        #1 chk("free_same_cycle_ready", 32'(ckpt_ready), 0);
        tick();
        chk("free_ready", 32'(ckpt_ready), 1);
        chk("free_id", 32'(ckpt_id), 2);
        ckpt_valid = 1; free_mask = 4'b0100; tick();
        chk("alloc_beats_free", 32'(ckpt_ready), 0);
        free_mask = 4'b1111; tick();
        chk("free_all_id", 32'(ckpt_id), 0);

        // restore drops same-cycle push and checkpoint
        do_push(32'h11); do_push(32'h22);
        ckpt_valid = 1; tick();
        do_push(32'h33);
        chk("pre_rest_dout", dout, 32'h33);
        restore_valid = 1; restore_id = 0; push = 1; din = 32'hCC; ckpt_valid = 1; tick();
        chk("drop_dout", dout, 32'h22);
        chk("drop_ready", 32'(ckpt_ready), 1);
        chk("drop_id", 32'(ckpt_id), 0);
        do_pop();
        chk("drop_pop_dout", dout, 32'h11);
        do_pop();
        chk("drop_pop2_empty", 32'(empty), 1);
        restore_valid = 1; restore_id = 1; push = 1; din = 32'hDD; tick();
        chk("inv_rest_push", dout, 32'hDD);
        chk("inv_rest_empty", 32'(empty), 0);
        do_pop();

        // asynchronous reset mid-sequence
        do_push(32'h1); do_push(32'h2); do_push(32'h3);
        ckpt_valid = 1; tick();
        ckpt_valid = 1; tick();
        chk("pre_arst_id", 32'(ckpt_id), 2);
        chk("pre_arst_dout", dout, 32'h3);
        #2 rst_n = 0;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_dout", dout, 0);
        chk("arst_ready", 32'(ckpt_ready), 1);
        chk("arst_id", 32'(ckpt_id), 0);
        chk("arst_full", 32'(full), 0);
        #10 rst_n = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
